// File: rtl/regfile_writeback_pkg.sv
// Shared types for the MIPS writeback slice: load type encoding and load-queue entry.
package mips_wb_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } ld_type_t;

    typedef struct packed {
        logic [4:0]  dest;
        ld_type_t    ltype;
        logic [1:0]  off;
        logic [31:0] rt_old;
    } ldq_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: ALU source, load issue, memory response, register-file write port and status.
interface regfile_writeback_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic        ld_ready;
    logic [4:0]  ld_dest;
    logic [2:0]  ld_type;
    logic [1:0]  ld_off;
    logic [31:0] ld_rt_old;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wren;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic        protocol_err;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_issue, ld_dest, ld_type, ld_off, ld_rt_old,
        output mem_rvalid, mem_rdata,
        input  alu_ready, ld_ready, rf_wren, rf_wr, rf_wd, busy, protocol_err
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_issue, ld_dest, ld_type, ld_off, ld_rt_old,
        input  mem_rvalid, mem_rdata,
        output alu_ready, ld_ready, rf_wren, rf_wr, rf_wd, busy, protocol_err
    );
endinterface

// File: rtl/regfile_writeback_load_align.sv
// Big-endian load extraction: selects/extends bytes and halves, merges LWL/LWR with old rt.
module load_align
    import mips_wb_pkg::*;
(
    input  ld_type_t    ltype,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] wd
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel = rdata[31:24];
        case (off)
            2'd0: bsel = rdata[31:24];
            2'd1: bsel = rdata[23:16];
            2'd2: bsel = rdata[15:8];
            2'd3: bsel = rdata[7:0];
            default: bsel = rdata[31:24];
        endcase
        hsel = off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        wd = rdata;
        case (ltype)
            LB:  wd = {{24{bsel[7]}}, bsel};
            LBU: wd = {24'h0, bsel};
            LH:  wd = {{16{hsel[15]}}, hsel};
            LHU: wd = {16'h0, hsel};
            LWL: begin
                case (off)
                    2'd0: wd = rdata;
                    2'd1: wd = {rdata[23:0], rt_old[7:0]};
                    2'd2: wd = {rdata[15:0], rt_old[15:0]};
                    2'd3: wd = {rdata[7:0],  rt_old[23:0]};
                    default: wd = rdata;
                endcase
            end
            LWR: begin
                case (off)
                    2'd3: wd = rdata;
                    2'd2: wd = {rt_old[31:24], rdata[31:8]};
                    2'd1: wd = {rt_old[31:16], rdata[31:16]};
                    2'd0: wd = {rt_old[31:8],  rdata[31:24]};
                    default: wd = rdata;
                endcase
            end
            default: wd = rdata;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Sole register-file writer: arbitrates ALU results against in-order load completions
// and publishes a per-register busy scoreboard for pending loads.
module regfile_writeback
    import mips_wb_pkg::*;
#(
    parameter int unsigned LDQ_DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    regfile_writeback_if.slave wb
);

    localparam int unsigned PW = $clog2(LDQ_DEPTH);

    ldq_entry_t    q [LDQ_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count, count_nxt;
    logic          empty, full, pop, push, alu_take, err_nxt;
    logic          wr_from_load;
    logic [31:0]   ld_wd;
    logic [31:0]   busy_v;
    logic [PW-1:0] idx;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(LDQ_DEPTH));
    assign pop      = wb.mem_rvalid && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign push     = wb.ld_issue && (!full || pop);
    assign alu_take = wb.alu_valid && !pop;
    assign err_nxt  = (wb.mem_rvalid && empty) || (wb.ld_issue && full && !pop);

    assign wb.alu_ready = !pop;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    load_align u_align (
        .ltype  (q[head].ltype),
        .off    (q[head].off),
        .rdata  (wb.mem_rdata),
        .rt_old (q[head].rt_old),
        .wd     (ld_wd)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            q[tail] <= '{dest: wb.ld_dest, ltype: ld_type_t'(wb.ld_type),
                         off: wb.ld_off, rt_old: wb.ld_rt_old};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            wb.ld_ready     <= 1'b1;
            wb.rf_wren      <= 1'b0;
            wb.rf_wr        <= '0;
            wb.rf_wd        <= '0;
            wr_from_load    <= 1'b0;
            wb.protocol_err <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count           <= count_nxt;
            wb.ld_ready     <= (count_nxt != (PW+1)'(LDQ_DEPTH));
            wb.protocol_err <= err_nxt;
            wb.rf_wren      <= 1'b0;
            wr_from_load    <= 1'b0;
            if (pop) begin
                wb.rf_wren   <= (q[head].dest != '0);
                wb.rf_wr     <= q[head].dest;
                wb.rf_wd     <= ld_wd;
                wr_from_load <= 1'b1;
            end else if (alu_take) begin
                wb.rf_wren   <= (wb.alu_dest != '0);
                wb.rf_wr     <= wb.alu_dest;
                wb.rf_wd     <= wb.alu_data;
            end
        end
    end

    // Busy covers every queued load plus the load write committing this cycle.
    always_comb begin
        busy_v = '0;
        idx    = '0;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            idx = head + PW'(i);
            if (i < 32'(count)) busy_v[q[idx].dest] = 1'b1;
        end
        if (wb.rf_wren && wr_from_load) busy_v[wb.rf_wr] = 1'b1;
        busy_v[0] = 1'b0;
    end

    assign wb.busy = busy_v;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model and per-cycle compare.
module tb_regfile_writeback;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    regfile_writeback_if bus ();

    regfile_writeback #(.LDQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [2:0]  t;
        logic [1:0]  off;
        logic [31:0] rt;
    } mld_t;

    mld_t        mq [$];
    logic        exp_wren, exp_from_load, exp_err;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;

    int checks = 0;
    int errors = 0;

    logic        pin_wd_en, pin_busy_en, pin_ready_en, pin_lr_en, pin_err_en, pin_nowr_en, pin_rst_en;
    logic [4:0]  pin_wr, pin_busy_idx;
    logic [31:0] pin_wd;
    logic        pin_busy_val, pin_ready_val, pin_lr_val, pin_err_val;

    // Reference extraction from a byte view of the memory word (byte 0 = most significant).
    function automatic logic [31:0] mdl_extract(input logic [2:0] t, input logic [1:0] off,
                                                input logic [31:0] mem, input logic [31:0] rt);
        logic [7:0]  mb [4];
        logic [7:0]  rb [4];
        logic [7:0]  ob [4];
        logic [7:0]  b;
        logic [15:0] h;
        int          o;
        o = int'(off);
        for (int j = 0; j < 4; j++) begin
            mb[j] = 8'(mem >> (24 - 8 * j));
            rb[j] = 8'(rt  >> (24 - 8 * j));
        end
        b = mb[o];
        h = {mb[o & 2], mb[(o & 2) + 1]};
        case (t)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {24'h0, b};
            3'd2: return {{16{h[15]}}, h};
            3'd3: return {16'h0, h};
            3'd5: begin
                for (int j = 0; j < 4; j++) ob[j] = (j < 4 - o) ? mb[o + j] : rb[j];
                return {ob[0], ob[1], ob[2], ob[3]};
            end
            3'd6: begin
                for (int j = 0; j < 4; j++) ob[j] = (j >= 3 - o) ? mb[j - (3 - o)] : rb[j];
                return {ob[0], ob[1], ob[2], ob[3]};
            end
            default: return mem;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_wren = 1'b0; exp_from_load = 1'b0; exp_err = 1'b0;
            exp_wr = '0; exp_wd = '0;
        end else begin
            int   n;
            logic mpop, mpush;
            mld_t e;
            n     = mq.size();
            mpop  = bus.mem_rvalid && (n > 0);
            mpush = bus.ld_issue && ((n < DEPTH) || mpop);
            exp_err       = (bus.mem_rvalid && n == 0) || (bus.ld_issue && n >= DEPTH && !mpop);
            exp_wren      = 1'b0;
            exp_from_load = 1'b0;
            if (mpop) begin
                e = mq.pop_front();
                exp_wren      = (e.dest != 0);
                exp_wr        = e.dest;
                exp_wd        = mdl_extract(e.t, e.off, bus.mem_rdata, e.rt);
                exp_from_load = 1'b1;
            end else if (bus.alu_valid) begin
                exp_wren = (bus.alu_dest != 0);
                exp_wr   = bus.alu_dest;
                exp_wd   = bus.alu_data;
            end
            if (mpush) begin
                e.dest = bus.ld_dest; e.t = bus.ld_type; e.off = bus.ld_off; e.rt = bus.ld_rt_old;
                mq.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] eb;
        eb = '0;
        foreach (mq[i]) eb[mq[i].dest] = 1'b1;
        if (exp_wren && exp_from_load) eb[exp_wr] = 1'b1;
        eb[0] = 1'b0;
        chk("alu_ready", 32'(bus.alu_ready), 32'(!(bus.mem_rvalid && mq.size() > 0)));
        chk("rf_wren", 32'(bus.rf_wren), 32'(exp_wren));
        if (exp_wren) begin
            chk("rf_wr", 32'(bus.rf_wr), 32'(exp_wr));
            chk("rf_wd", bus.rf_wd, exp_wd);
        end
        chk("busy", bus.busy, eb);
        chk("ld_ready", 32'(bus.ld_ready), 32'(mq.size() < DEPTH));
        chk("protocol_err", 32'(bus.protocol_err), 32'(exp_err));
        if (pin_wd_en) begin
            chk("pin_wren", 32'(bus.rf_wren), 32'd1);
            chk("pin_wr", 32'(bus.rf_wr), 32'(pin_wr));
            chk("pin_wd", bus.rf_wd, pin_wd);
        end
        if (pin_busy_en)  chk("pin_busy", 32'(bus.busy[pin_busy_idx]), 32'(pin_busy_val));
        if (pin_ready_en) chk("pin_alu_ready", 32'(bus.alu_ready), 32'(pin_ready_val));
        if (pin_lr_en)    chk("pin_ld_ready", 32'(bus.ld_ready), 32'(pin_lr_val));
        if (pin_err_en)   chk("pin_protocol_err", 32'(bus.protocol_err), 32'(pin_err_val));
        if (pin_nowr_en)  chk("pin_no_write", 32'(bus.rf_wren), 32'd0);
        if (pin_rst_en) begin
            chk("pin_rst_wr", 32'(bus.rf_wr), 32'd0);
            chk("pin_rst_wd", bus.rf_wd, 32'd0);
            chk("pin_rst_busy", bus.busy, 32'd0);
            chk("pin_rst_ready", 32'(bus.ld_ready), 32'd1);
        end
    end

    task automatic clr_pins();
        pin_wd_en = 0; pin_busy_en = 0; pin_ready_en = 0; pin_lr_en = 0;
        pin_err_en = 0; pin_nowr_en = 0; pin_rst_en = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr_pins();
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.ld_issue = 0; bus.ld_dest = '0; bus.ld_type = '0; bus.ld_off = '0; bus.ld_rt_old = '0;
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic issue(input logic [4:0] d, input logic [2:0] t, input logic [1:0] o,
                         input logic [31:0] rt);
        bus.ld_issue = 1; bus.ld_dest = d; bus.ld_type = t; bus.ld_off = o; bus.ld_rt_old = rt;
    endtask

    task automatic pin_write(input logic [4:0] r, input logic [31:0] v);
        pin_wd_en = 1; pin_wr = r; pin_wd = v;
    endtask

    task automatic pin_busy(input logic [4:0] r, input logic v);
        pin_busy_en = 1; pin_busy_idx = r; pin_busy_val = v;
    endtask

    task automatic do_load(input logic [4:0] d, input logic [2:0] t, input logic [1:0] o,
                           input logic [31:0] rt, input logic [31:0] mem, input logic [31:0] expv);
        issue(d, t, o, rt);
        cyc();
        bus.ld_issue = 0; bus.mem_rvalid = 1; bus.mem_rdata = mem;
        pin_busy(d, 1);
        cyc();
        bus.mem_rvalid = 0;
        pin_write(d, expv);
        pin_busy(d, 1);
        cyc();
        pin_busy(d, 0);
    endtask

    initial begin
        clr_pins();
        idle();
        rst_n = 0;
        cyc();
        pin_rst_en = 1;
        cyc();
        rst_n = 1;

        // ALU write with idle memory
        bus.alu_valid = 1; bus.alu_dest = 5'd5; bus.alu_data = 32'hDEADBEEF;
        pin_ready_en = 1; pin_ready_val = 1;
        cyc();
        idle();
        pin_write(5'd5, 32'hDEADBEEF);
        cyc();

        // Load extraction
        do_load(5'd3, 3'd0, 2'd1, 32'h0,        32'h12803456, 32'hFFFFFF80);
        do_load(5'd3, 3'd1, 2'd1, 32'h0,        32'h12803456, 32'h00000080);
        do_load(5'd4, 3'd5, 2'd2, 32'hAAAABBBB, 32'h11223344, 32'h3344BBBB);
        do_load(5'd4, 3'd6, 2'd1, 32'hAAAABBBB, 32'h11223344, 32'hAAAA1122);
        do_load(5'd6, 3'd2, 2'd2, 32'h0,        32'h1234ABCD, 32'hFFFFABCD);
        do_load(5'd6, 3'd3, 2'd3, 32'h0,        32'h1234ABCD, 32'h0000ABCD);
        do_load(5'd8, 3'd4, 2'd2, 32'h0,        32'h11223344, 32'h11223344);
        do_load(5'd8, 3'd5, 2'd0, 32'hAAAABBBB, 32'h11223344, 32'h11223344);
        do_load(5'd8, 3'd6, 2'd3, 32'hAAAABBBB, 32'h11223344, 32'h11223344);
        do_load(5'd9, 3'd0, 2'd3, 32'h0,        32'h1234567F, 32'h0000007F);
        do_load(5'd9, 3'd7, 2'd1, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D);
        do_load(5'd31, 3'd5, 2'd3, 32'h01020304, 32'h55667788, 32'h88020304);
        do_load(5'd31, 3'd6, 2'd0, 32'h01020304, 32'h55667788, 32'h01020355);

        // Two loads to r7: busy holds until the younger one writes
        issue(5'd7, 3'd4, 2'd0, 32'h0);
        cyc();
        issue(5'd7, 3'd4, 2'd0, 32'h0);
        pin_busy(5'd7, 1); pin_lr_en = 1; pin_lr_val = 1;
        cyc();
        bus.ld_issue = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h11111111;
        pin_busy(5'd7, 1); pin_lr_en = 1; pin_lr_val = 0;
        cyc();
        bus.mem_rdata = 32'h22222222;
        pin_write(5'd7, 32'h11111111); pin_busy(5'd7, 1);
        cyc();
        bus.mem_rvalid = 0;
        pin_write(5'd7, 32'h22222222); pin_busy(5'd7, 1);
        cyc();
        pin_busy(5'd7, 0);
        cyc();

        // Load completion beats a simultaneous ALU offer
        issue(5'd9, 3'd4, 2'd0, 32'h0);
        cyc();
        bus.ld_issue = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00000099;
        bus.alu_valid = 1; bus.alu_dest = 5'd10; bus.alu_data = 32'h0000000A;
        pin_ready_en = 1; pin_ready_val = 0;
        cyc();
        bus.mem_rvalid = 0;
        pin_ready_en = 1; pin_ready_val = 1;
        pin_write(5'd9, 32'h00000099);
        cyc();
        bus.alu_valid = 0;
        pin_write(5'd10, 32'h0000000A);
        cyc();

        // Overflow and full-queue push+pop
        issue(5'd1, 3'd4, 2'd0, 32'h0);
        cyc();
        issue(5'd2, 3'd4, 2'd0, 32'h0);
        cyc();
        issue(5'd3, 3'd4, 2'd0, 32'h0);
        pin_lr_en = 1; pin_lr_val = 0;
        cyc();
        issue(5'd4, 3'd4, 2'd0, 32'h0);
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h01010101;
        pin_err_en = 1; pin_err_val = 1; pin_busy(5'd3, 0);
        cyc();
        bus.ld_issue = 0; bus.mem_rdata = 32'h02020202;
        pin_err_en = 1; pin_err_val = 0; pin_lr_en = 1; pin_lr_val = 0;
        pin_write(5'd1, 32'h01010101);
        cyc();
        bus.mem_rdata = 32'h04040404;
        pin_write(5'd2, 32'h02020202);
        cyc();
        bus.mem_rvalid = 0;
        pin_write(5'd4, 32'h04040404); pin_lr_en = 1; pin_lr_val = 1;
        cyc();

        // Reset with loads pending, then a stray response
        issue(5'd11, 3'd4, 2'd0, 32'h0);
        cyc();
        issue(5'd12, 3'd4, 2'd0, 32'h0);
        cyc();
        bus.ld_issue = 0;
        rst_n = 0;
        #1;
        pin_rst_en = 1;
        cyc();
        rst_n = 1;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
        cyc();
        bus.mem_rvalid = 0;
        pin_err_en = 1; pin_err_val = 1; pin_nowr_en = 1;
        cyc();

        // Writes to r0 from either source are suppressed
        bus.alu_valid = 1; bus.alu_dest = 5'd0; bus.alu_data = 32'hFFFFFFFF;
        cyc();
        bus.alu_valid = 0;
        pin_nowr_en = 1;
        cyc();
        issue(5'd0, 3'd4, 2'd0, 32'h0);
        cyc();
        bus.ld_issue = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h87654321;
        pin_busy(5'd0, 0);
        cyc();
        bus.mem_rvalid = 0;
        pin_nowr_en = 1; pin_err_en = 1; pin_err_val = 0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
